// File: rtl/alu_shift_seq_pkg.sv
// Shared definitions: ALU opcode mnemonics and the
// shift-sequencer state encoding.
package alu_shift_seq_pkg;

    typedef enum logic [2:0] {
        kADD = 3'd0,
        kSUB = 3'd1,
        kLSH = 3'd2,
        kRSH = 3'd3,
        kXOR = 3'd4,
        kAND = 3'd5,
        kOR  = 3'd6,
        kNOT = 3'd7
    } op_mne;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        SECOND,
        PAR,
        FIN
    } seq_state_t;

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU with shift/carry chaining
// and odd-parity flag on its result.
module alu
    import alu_shift_seq_pkg::*;
(
    input  logic [7:0] INPUTA,
    input  logic [7:0] INPUTB,
    input  logic [2:0] OP,
    input  logic       SC_IN,
    output logic [7:0] OUT,
    output logic       SC_OUT,
    output logic       BEVEN
);

    always_comb begin
        OUT    = '0;
        SC_OUT = 1'b0;
        case (op_mne'(OP))
            kADD: {SC_OUT, OUT} = {1'b0, INPUTA} + {1'b0, INPUTB}
                                + {8'b0, SC_IN};
            kSUB: {SC_OUT, OUT} = {1'b0, INPUTA} - {1'b0, INPUTB};
            kLSH: begin
                OUT    = {INPUTA[6:0], SC_IN};
                SC_OUT = INPUTA[7];
            end
            kRSH: begin
                OUT    = {SC_IN, INPUTA[7:1]};
                SC_OUT = INPUTA[0];
            end
            kXOR: OUT = INPUTA ^ INPUTB;
            kAND: OUT = INPUTA & INPUTB;
            kOR:  OUT = INPUTA | INPUTB;
            kNOT: OUT = ~INPUTA;
            default: OUT = '0;
        endcase
        BEVEN = ^OUT;
    end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle 16-bit shifter driving the 8-bit ALU one
// byte per cycle, with a closing parity/zero pass.
module alu_shift_seq
    import alu_shift_seq_pkg::*;
#(
    parameter int W_AMT = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             START,
    input  logic             DIR,
    input  logic [W_AMT-1:0] AMOUNT,
    input  logic             FILL,
    input  logic [15:0]      DIN,
    output logic [7:0]       ALU_A,
    output logic [7:0]       ALU_B,
    output logic [2:0]       ALU_OP,
    output logic             ALU_SC_IN,
    input  logic [7:0]       ALU_OUT,
    input  logic             ALU_SC_OUT,
    input  logic             ALU_BEVEN,
    output logic             BUSY,
    output logic             DONE,
    output logic [15:0]      DOUT,
    output logic             LASTOUT,
    output logic             PARITY,
    output logic             ZERO
);

    seq_state_t       state_q, state_d;
    logic [15:0]      dout_q, dout_d;
    logic [W_AMT-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             fill_q, fill_d;
    logic             carry_q, carry_d;
    logic             last_q, last_d;
    logic             par_q, par_d;
    logic             zero_q, zero_d;
    op_mne            op;

    always_comb begin
        state_d   = state_q;
        dout_d    = dout_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        fill_d    = fill_q;
        carry_d   = carry_q;
        last_d    = last_q;
        par_d     = par_q;
        zero_d    = zero_q;
        op        = kAND;
        ALU_A     = '0;
        ALU_B     = '0;
        ALU_SC_IN = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    dout_d  = DIN;
                    dir_d   = DIR;
                    fill_d  = FILL;
                    cnt_d   = AMOUNT;
                    last_d  = 1'b0;
                    state_d = (AMOUNT == '0) ? PAR : FIRST;
                end
            end
            FIRST: begin
                // Left starts at the LSW, right at the MSW, so the
                // carry always flows toward the far byte.
                op        = dir_q ? kRSH : kLSH;
                ALU_SC_IN = fill_q;
                if (dir_q) begin
                    ALU_A         = dout_q[15:8];
                    dout_d[15:8]  = ALU_OUT;
                end else begin
                    ALU_A         = dout_q[7:0];
                    dout_d[7:0]   = ALU_OUT;
                end
                carry_d = ALU_SC_OUT;
                state_d = SECOND;
            end
            SECOND: begin
                op        = dir_q ? kRSH : kLSH;
                ALU_SC_IN = carry_q;
                if (dir_q) begin
                    ALU_A         = dout_q[7:0];
                    dout_d[7:0]   = ALU_OUT;
                end else begin
                    ALU_A         = dout_q[15:8];
                    dout_d[15:8]  = ALU_OUT;
                end
                last_d  = ALU_SC_OUT;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == W_AMT'(1)) ? PAR : FIRST;
            end
            PAR: begin
                op      = kXOR;
                ALU_A   = dout_q[15:8];
                ALU_B   = dout_q[7:0];
                par_d   = ALU_BEVEN;
                zero_d  = (dout_q == '0);
                state_d = FIN;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            dout_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            carry_q <= 1'b0;
            last_q  <= 1'b0;
            par_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
            carry_q <= carry_d;
            last_q  <= last_d;
            par_q   <= par_d;
            zero_q  <= zero_d;
        end
    end

    assign ALU_OP  = op;
    assign BUSY    = (state_q != IDLE);
    assign DONE    = (state_q == FIN);
    assign DOUT    = dout_q;
    assign LASTOUT = last_q;
    assign PARITY  = par_q;
    assign ZERO    = zero_q;

endmodule

// File: doc/alu_shift_seq.md
Name: alu_shift_seq

Overview:
- Multi-cycle controller that performs 16-bit shifts of 0..15 positions using the 8-bit combinational ALU.
- The word is held as two bytes (LSW/MSW). For each bit position the controller issues two ALU passes (kLSH or kRSH) and chains the carry between bytes through SC_IN/SC_OUT.
- A final kXOR pass of MSW against LSW captures word parity from BEVEN.
- Sits between the control unit (start/done handshake) and the ALU port mux.

Parameters:
- W_AMT, 4, width of shift-amount field; maximum shift is 2^W_AMT-1.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-low reset.
- START  input  1  request, sampled only in IDLE.
- DIR  input  1  0 = left shift, 1 = right shift; latched at start.
- AMOUNT  input  W_AMT  number of bit positions; latched at start.
- FILL  input  1  bit shifted into the vacated end on every iteration; latched at start.
- DIN  input  16  operand; latched at start.
- ALU_A  output  8  ALU INPUTA.
- ALU_B  output  8  ALU INPUTB.
- ALU_OP  output  3  ALU opcode, taken from the definitions package.
- ALU_SC_IN  output  1  ALU shift/carry in.
- ALU_OUT  input  8  ALU result.
- ALU_SC_OUT  input  1  ALU carry/shift out.
- ALU_BEVEN  input  1  ALU parity of OUT (1 = odd).
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle pulse; result outputs are valid in that cycle.
- DOUT  output  16  working/result register; holds its value until the next accepted START.
- LASTOUT  output  1  last bit shifted off the word end; 0 if AMOUNT = 0.
- PARITY  output  1  odd-ones flag of the result.
- ZERO  output  1  result == 0.

Behaviour:
- Reset (Reset = 0 at an edge): go to IDLE; DOUT, LASTOUT, PARITY, ZERO, DONE, BUSY, counter and carry register all cleared. Reset wins over every other event, including mid-operation; the operation in progress is discarded with no DONE.
- States: IDLE, FIRST, SECOND, PAR, FIN.
- IDLE, START = 1: latch DIN into DOUT, latch DIR/FILL, load cnt = AMOUNT, clear LASTOUT. Next state is PAR if AMOUNT = 0, else FIRST.
- FIRST:
  - ALU_OP = kLSH if DIR = 0, kRSH if DIR = 1.
  - ALU_A = DOUT[7:0] when left, DOUT[15:8] when right; ALU_SC_IN = FILL.
  - At the edge: write ALU_OUT back to that byte, store ALU_SC_OUT in the carry register; next state SECOND.
- SECOND:
  - Same opcode as FIRST, operating on the other byte; ALU_SC_IN = carry register.
  - At the edge: write ALU_OUT back, LASTOUT <= ALU_SC_OUT, cnt <= cnt-1.
  - Next state PAR if cnt == 1, else FIRST.
- PAR:
  - ALU_OP = kXOR, ALU_A = DOUT[15:8], ALU_B = DOUT[7:0].
  - At the edge: PARITY <= ALU_BEVEN, ZERO <= (DOUT == 0); next state FIN.
- FIN: DONE = 1; next state IDLE.
- ALU drive outside the shift/parity states:
  - In IDLE and FIN: ALU_OP = kAND, ALU_A = ALU_B = 0, ALU_SC_IN = 0.
  - ALU_B = 0 in FIRST and SECOND.
- Latency: with START sampled at edge E0, DONE is high in the cycle after edge E(2*AMOUNT+1). The controller is ready for the next START in the cycle after DONE (back-to-back requests are allowed).
- START outside IDLE is ignored (no queueing).
- Inputs other than ALU_* are not sampled after the start edge.
- All outputs are registered except ALU_* and DONE/BUSY, which decode from the state register.
- Width rules:
  - Left shift: bit 7 of LSW carries into bit 0 of MSW.
  - Right shift: bit 8 carries into bit 7.
  - Bits shifted past the word end are lost except the final one, which is reported on LASTOUT.

Decomposition:
- State enum seq_state_t {IDLE, FIRST, SECOND, PAR, FIN} is added to the shared definitions package alongside op_mne and the kLSH/kRSH/kXOR/kAND constants; the block imports that package.
- No sub-module: one FSM plus datapath registers, roughly 150 lines.
- The testbench instantiates the real ALU and wires it to the ALU_* ports.

Test Plan:
- Left, DIN = 16'h8001, AMOUNT = 1, FILL = 0 -> DOUT = 16'h0002, LASTOUT = 1, PARITY = 1, ZERO = 0; DONE after edge E3; ALU_OP sequence LSH, LSH, XOR.
- Right, DIN = 16'h8001, AMOUNT = 4, FILL = 1 -> DOUT = 16'hF800, LASTOUT = 0, PARITY = 1; DONE after edge E9; MSW is operated before LSW in every iteration.
- AMOUNT = 0, DIN = 16'h00F0 -> DOUT = 16'h00F0, LASTOUT = 0, PARITY = 0, ZERO = 0; DONE after edge E1.
- Right, DIN = 16'h0001, AMOUNT = 1, FILL = 0 -> DOUT = 0, ZERO = 1, LASTOUT = 1, PARITY = 0.
- Left, DIN = 16'h1234, AMOUNT = 15, plus a second START pulsed at cycle 5 -> the second START is ignored; DOUT = 16'h0000, LASTOUT = 0; DONE exactly once, after edge E31.
- Reset = 0 for one edge during SECOND of a 6-bit shift -> next cycle IDLE, BUSY = 0, all outputs 0, no DONE; a fresh START afterwards completes normally.
